ate_raster_packer: RTL and testbench

ATE_RASTER_PACKER -- requirements
Module: ate_raster_packer

---
 rtl/ate_raster_packer.sv | 196 +++++++++++++++++++
 tb/tb_ate_raster_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ate_raster_packer.sv
`default_nettype none
// ============================================================================
// ate_raster_packer : repacks a block-major binarized pixel stream into
// raster-order bytes through two ping-pong block-row banks.   Rev 1.0
// ============================================================================
module ate_raster_packer #(
  parameter int BLK   = 8,
  parameter int BLK_W = 6,
  parameter int BLK_H = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bin_in,
  input  logic       bin_valid,
  output logic       bin_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [4:0] row_idx,
  output logic [2:0] col_idx,
  output logic       frame_done,
  output logic       overflow
);

  localparam logic [5:0] LAST_P   = 6'(BLK * BLK - 1);
  localparam logic [2:0] LAST_BX  = 3'(BLK_W - 1);
  localparam logic [1:0] LAST_BY  = 2'(BLK_H - 1);
  localparam logic [2:0] LAST_R   = 3'(BLK - 1);
  localparam logic [4:0] LAST_ROW = 5'(BLK * BLK_H - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [5:0]      p_q, p_d;
  logic [2:0]      bx_q, bx_d;
  logic [1:0]      by_q, by_d;
  logic            wsel_q, wsel_d;
  logic            rsel_q, rsel_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][1:0] full_by_q, full_by_d;
  logic [2:0]      rrow_q, rrow_d;
  logic [2:0]      rcol_q, rcol_d;
  logic [7:0]      byte_q, byte_d;
  logic            bvalid_q, bvalid_d;
  logic [4:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic            ovf_q, ovf_d;

  logic [47:0]     bank_q [2][8];

  logic            accept;
  logic            xfer;
  logic            load;
  logic            rd_sel;
  logic [2:0]      rd_row;
  logic [2:0]      rd_col;

  assign bin_ready  = ~full_q[wsel_q];
  assign accept     = bin_valid & bin_ready;
  assign xfer       = bvalid_q & byte_ready;
  assign byte_out   = byte_q;
  assign byte_valid = bvalid_q;
  assign row_idx    = row_q;
  assign col_idx    = col_q;
  assign overflow   = ovf_q;
  assign frame_done = xfer && (row_q == LAST_ROW) && (col_q == LAST_BX);

  // Pixel c of a block row lands MSB-first: bit (7-c) of byte bx is {bx, ~c}.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[wsel_q][p_q[5:3]][{bx_q, ~p_q[2:0]}] <= bin_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    bx_d      = bx_q;
    by_d      = by_q;
    wsel_d    = wsel_q;
    rsel_d    = rsel_q;
    full_d    = full_q;
    full_by_d = full_by_q;
    rrow_d    = rrow_q;
    rcol_d    = rcol_q;
    byte_d    = byte_q;
    bvalid_d  = bvalid_q;
    row_d     = row_q;
    col_d     = col_q;
    ovf_d     = ovf_q | (bin_valid & ~bin_ready);
    load      = 1'b0;
    rd_sel    = rsel_q;
    rd_row    = rrow_q;
    rd_col    = rcol_q;

    if (accept) begin
      p_d = p_q + 6'd1;
      if (p_q == LAST_P) begin
        bx_d = (bx_q == LAST_BX) ? 3'd0 : bx_q + 3'd1;
        if (bx_q == LAST_BX) begin
          by_d              = (by_q == LAST_BY) ? 2'd0 : by_q + 2'd1;
          full_d[wsel_q]    = 1'b1;
          full_by_d[wsel_q] = by_q;
          wsel_d            = ~wsel_q;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rsel_q]) begin
          state_d = DRAIN;
          rrow_d  = 3'd0;
          rcol_d  = 3'd0;
        end
      end
      DRAIN: begin
        if (!bvalid_q) begin
          load = 1'b1;
        end else if (byte_ready) begin
          if ((rrow_q == LAST_R) && (rcol_q == LAST_BX)) begin
            // The draining bank is never the one being written, so this clear
            // cannot collide with a same-cycle completion into the other bank.
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
            if (full_q[~rsel_q]) begin
              rd_sel = ~rsel_q;
              rd_row = 3'd0;
              rd_col = 3'd0;
              load   = 1'b1;
            end else begin
              state_d  = IDLE;
              bvalid_d = 1'b0;
            end
          end else begin
            if (rcol_q == LAST_BX) begin
              rd_row = rrow_q + 3'd1;
              rd_col = 3'd0;
            end else begin
              rd_col = rcol_q + 3'd1;
            end
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      rrow_d   = rd_row;
      rcol_d   = rd_col;
      bvalid_d = 1'b1;
      byte_d   = bank_q[rd_sel][rd_row][{rd_col, 3'b000} +: 8];
      row_d    = {full_by_q[rd_sel], rd_row};
      col_d    = rd_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      p_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      full_q    <= '0;
      full_by_q <= '0;
      rrow_q    <= '0;
      rcol_q    <= '0;
      byte_q    <= '0;
      bvalid_q  <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      full_q    <= full_d;
      full_by_q <= full_by_d;
      rrow_q    <= rrow_d;
      rcol_q    <= rcol_d;
      byte_q    <= byte_d;
      bvalid_q  <= bvalid_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ate_raster_packer.sv
`default_nettype none
// Testbench for ate_raster_packer: random frames against a raster-image model.
module tb_ate_raster_packer;

  logic       clk;
  logic       reset;
  logic       bin_in;
  logic       bin_valid;
  logic       bin_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic [4:0] row_idx;
  logic [2:0] col_idx;
  logic       frame_done;
  logic       overflow;

  ate_raster_packer #(.BLK(8), .BLK_W(6), .BLK_H(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bin_in     (bin_in),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic       px       [0:3071];
  logic [7:0] exp_byte [0:383];
  logic [7:0] obs_byte [0:399];
  int         obs_row  [0:399];
  int         obs_col  [0:399];
  logic       obs_fd   [0:399];
  int         n_obs;
  int         fd_count;
  int         stall_bad;
  int         in_block;
  int         first_acc;
  int         first_valid;

  // Reference: place each pixel in a 32x48 image by block-major arithmetic,
  // then read the image back in raster order, leftmost pixel as MSB.
  function automatic void build_expected(input int nframes);
    logic img [0:31][0:47];
    logic [7:0] b;
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < 1536; i++) begin
        int blk = i / 64;
        int p   = i % 64;
        img[(blk / 6) * 8 + p / 8][(blk % 6) * 8 + p % 8] = px[f * 1536 + i];
      end
      for (int r = 0; r < 32; r++) begin
        for (int c = 0; c < 6; c++) begin
          for (int k = 0; k < 8; k++) b[7 - k] = img[r][c * 8 + k];
          exp_byte[f * 192 + r * 6 + c] = b;
        end
      end
    end
  endfunction

  function automatic int stream_errors(input int nexp);
    int errs = 0;
    for (int j = 0; j < nexp; j++) begin
      if (obs_byte[j] !== exp_byte[j] || obs_row[j] != (j % 192) / 6 ||
          obs_col[j] != j % 6 || obs_fd[j] !== ((j % 192) == 191)) begin
        if (errs == 0)
          $display("  first diff at byte %0d: got %02h r%0d c%0d fd%0b want %02h r%0d c%0d",
                   j, obs_byte[j], obs_row[j], obs_col[j], obs_fd[j], exp_byte[j],
                   (j % 192) / 6, j % 6);
        errs++;
      end
    end
    return errs;
  endfunction

  function automatic void fill_random(input int n);
    for (int i = 0; i < n; i++) px[i] = 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bin_valid = 1'b0; bin_in = 1'b0; byte_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Streams px[0..npix-1] and collects transfers; mode 0 ready=1, 1 ready random.
  task automatic run_stream(input int npix, input int mode, input int nexp,
                            input int stop_at, input int budget, output int timed_out);
    int pi = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] pb = '0;
    logic [4:0] pr = '0;
    logic [2:0] pc = '0;
    n_obs = 0; fd_count = 0; stall_bad = 0; in_block = 0;
    first_acc = -1; first_valid = -1;
    while ((pi < npix || n_obs < nexp) && n_obs < stop_at && cyc < budget) begin
      if (pi < npix) begin bin_valid = 1'b1; bin_in = px[pi]; end
      else begin bin_valid = 1'b0; bin_in = 1'b0; end
      byte_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall && (byte_valid !== 1'b1 || byte_out !== pb || row_idx !== pr || col_idx !== pc))
        stall_bad++;
      prev_stall = byte_valid && !byte_ready;
      pb = byte_out; pr = row_idx; pc = col_idx;
      if (byte_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (bin_valid && bin_ready !== 1'b1) in_block++;
      if (bin_valid && bin_ready === 1'b1) begin
        if (pi == 383) first_acc = cyc;
        pi++;
      end
      if (frame_done === 1'b1) fd_count++;
      if (byte_valid === 1'b1 && byte_ready && n_obs < 400) begin
        obs_byte[n_obs] = byte_out;
        obs_row[n_obs]  = int'(row_idx);
        obs_col[n_obs]  = int'(col_idx);
        obs_fd[n_obs]   = frame_done;
        n_obs++;
      end
      @(negedge clk);
      cyc++;
    end
    timed_out = (cyc >= budget) ? 1 : 0;
    bin_valid = 1'b0;
  endtask

  task automatic test_all_ones();
    int to, errs;
    do_reset();
    for (int i = 0; i < 1536; i++) px[i] = 1'b1;
    build_expected(1);
    run_stream(1536, 0, 192, 1000, 5000, to);
    n_total++; if (to !== 0) $display("FAIL ones_timeout: got %0d want 0", to); else n_pass++;
    n_total++; if (n_obs !== 192) $display("FAIL ones_count: got %0d want 192", n_obs); else n_pass++;
    errs = stream_errors(192);
    n_total++; if (errs !== 0) $display("FAIL ones_stream: got %0d bad bytes want 0", errs); else n_pass++;
    n_total++; if (fd_count !== 1) $display("FAIL ones_frame_done: got %0d pulses want 1", fd_count); else n_pass++;
    n_total++;
    if (first_valid - first_acc !== 3)
      $display("FAIL ones_latency: got %0d negedges want 3", first_valid - first_acc);
    else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL ones_overflow: got %0b want 0", overflow); else n_pass++;
  endtask

  task automatic test_single_pixel();
    int to, errs, nz, nz_r, nz_c;
    logic [7:0] nz_v;
    do_reset();
    for (int i = 0; i < 1536; i++) px[i] = 1'b0;
    px[7 * 64 + 9] = 1'b1;
    build_expected(1);
    run_stream(1536, 0, 192, 1000, 5000, to);
    n_total++; if (to !== 0) $display("FAIL single_timeout: got %0d want 0", to); else n_pass++;
    errs = stream_errors(192);
    n_total++; if (errs !== 0) $display("FAIL single_stream: got %0d bad bytes want 0", errs); else n_pass++;
    nz = 0; nz_r = -1; nz_c = -1; nz_v = '0;
    for (int j = 0; j < n_obs; j++) begin
      if (obs_byte[j] != 8'h00) begin nz++; nz_r = obs_row[j]; nz_c = obs_col[j]; nz_v = obs_byte[j]; end
    end
    n_total++; if (nz !== 1) $display("FAIL single_nonzero_count: got %0d want 1", nz); else n_pass++;
    n_total++;
    if (nz_r !== 9 || nz_c !== 1 || nz_v !== 8'h40)
      $display("FAIL single_position: got r%0d c%0d %02h want r9 c1 40", nz_r, nz_c, nz_v);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int ready_bad = 0;
    int unstable = 0;
    logic rdy769, ovf_before;
    logic [7:0] hb;
    logic [4:0] hr;
    logic [2:0] hc;
    do_reset();
    fill_random(1536);
    build_expected(1);
    rdy769 = 1'b1; ovf_before = 1'b1;
    for (int k = 0; k < 769; k++) begin
      bin_valid = 1'b1; bin_in = px[k]; byte_ready = 1'b0;
      #1;
      if (k < 768 && bin_ready !== 1'b1) ready_bad++;
      if (k == 768) begin rdy769 = bin_ready; ovf_before = overflow; end
      @(negedge clk);
    end
    bin_valid = 1'b0;
    #1;
    n_total++; if (ready_bad !== 0) $display("FAIL ovf_early_stall: got %0d want 0", ready_bad); else n_pass++;
    n_total++; if (rdy769 !== 1'b0) $display("FAIL ovf_ready_after_768: got %0b want 0", rdy769); else n_pass++;
    n_total++; if (ovf_before !== 1'b0) $display("FAIL ovf_premature: got %0b want 0", ovf_before); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %0b want 1", overflow); else n_pass++;
    n_total++; if (byte_valid !== 1'b1) $display("FAIL ovf_valid: got %0b want 1", byte_valid); else n_pass++;
    n_total++;
    if (row_idx !== 5'd0 || col_idx !== 3'd0 || byte_out !== exp_byte[0])
      $display("FAIL ovf_head_byte: got r%0d c%0d %02h want r0 c0 %02h", row_idx, col_idx, byte_out, exp_byte[0]);
    else n_pass++;
    hb = byte_out; hr = row_idx; hc = col_idx;
    repeat (4) begin
      @(negedge clk); #1;
      if (byte_valid !== 1'b1 || byte_out !== hb || row_idx !== hr || col_idx !== hc || overflow !== 1'b1)
        unstable++;
    end
    n_total++; if (unstable !== 0) $display("FAIL ovf_hold: got %0d unstable cycles want 0", unstable); else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; bin_valid = 1'b0; byte_ready = 1'b0;
    @(negedge clk); #1;
    n_total++; if (byte_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", byte_valid); else n_pass++;
    n_total++; if (byte_out !== 8'h00) $display("FAIL rst_byte: got %02h want 00", byte_out); else n_pass++;
    n_total++;
    if (row_idx !== 5'd0 || col_idx !== 3'd0)
      $display("FAIL rst_idx: got r%0d c%0d want r0 c0", row_idx, col_idx);
    else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %0b want 0", frame_done); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %0b want 0", overflow); else n_pass++;
    n_total++; if (bin_ready !== 1'b1) $display("FAIL rst_bin_ready: got %0b want 1", bin_ready); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random_ready();
    int to, errs;
    do_reset();
    fill_random(1536);
    build_expected(1);
    run_stream(1536, 1, 192, 1000, 8000, to);
    n_total++; if (to !== 0) $display("FAIL rand_timeout: got %0d want 0", to); else n_pass++;
    errs = stream_errors(192);
    n_total++; if (errs !== 0 || n_obs !== 192)
      $display("FAIL rand_stream: got %0d bad of %0d bytes want 0 of 192", errs, n_obs);
    else n_pass++;
    n_total++; if (fd_count !== 1) $display("FAIL rand_frame_done: got %0d want 1", fd_count); else n_pass++;
    n_total++; if (stall_bad !== 0) $display("FAIL rand_hold: got %0d want 0", stall_bad); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rand_overflow: got %0b want 0", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    int to, errs;
    do_reset();
    fill_random(1536);
    run_stream(1536, 0, 192, 20, 5000, to);
    n_total++; if (n_obs !== 20) $display("FAIL mid_bytes_before_reset: got %0d want 20", n_obs); else n_pass++;
    reset = 1'b0;
    @(negedge clk); #1;
    n_total++; if (byte_valid !== 1'b0) $display("FAIL mid_valid: got %0b want 0", byte_valid); else n_pass++;
    n_total++; if (bin_ready !== 1'b1) $display("FAIL mid_bin_ready: got %0b want 1", bin_ready); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    fill_random(1536);
    build_expected(1);
    run_stream(1536, 0, 192, 1000, 5000, to);
    errs = stream_errors(192);
    n_total++; if (to !== 0 || n_obs !== 192 || errs !== 0)
      $display("FAIL mid_next_frame: got %0d bad of %0d bytes timeout %0d want 0 of 192", errs, n_obs, to);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int to, errs;
    do_reset();
    fill_random(3072);
    build_expected(2);
    run_stream(3072, 0, 384, 1000, 9000, to);
    n_total++; if (to !== 0) $display("FAIL b2b_timeout: got %0d want 0", to); else n_pass++;
    errs = stream_errors(384);
    n_total++; if (errs !== 0 || n_obs !== 384)
      $display("FAIL b2b_stream: got %0d bad of %0d bytes want 0 of 384", errs, n_obs);
    else n_pass++;
    n_total++; if (in_block !== 0) $display("FAIL b2b_stall: got %0d blocked cycles want 0", in_block); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %0b want 0", overflow); else n_pass++;
    n_total++; if (fd_count !== 2) $display("FAIL b2b_frame_done: got %0d want 2", fd_count); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; bin_in = 1'b0; bin_valid = 1'b0; byte_ready = 1'b0;
    test_all_ones();
    test_single_pixel();
    test_overflow();
    test_reset();
    test_random_ready();
    test_reset_mid_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
